// File: rtl/otn_pkg.sv
// rtl/otn_pkg.sv - shared types and constants for the ARQ ack transmitter
package otn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_e;

   localparam logic [7:0] ACK_CODE_DEF = 8'h06;
   localparam logic [7:0] NAK_CODE_DEF = 8'h15;

   // start bit + 8 data bits + stop bit
   localparam int WORD_BITS = 10;
   localparam int DATA_BITS = WORD_BITS - 2;

endpackage

// File: rtl/arq_ack_tx_bit_timer.sv
// rtl/arq_ack_tx_bit_timer.sv - bit-period counter with terminal and pre-terminal pulses
module bit_timer #(
   parameter int BIT_CYCLES = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   output logic o_tick,
   output logic o_pre_tick
);

   localparam int CW = $clog2(BIT_CYCLES);
   localparam logic [CW-1:0] LAST_CNT = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] PRE_CNT  = CW'(BIT_CYCLES - 2);

   logic [CW-1:0] cnt_q, cnt_d;

   assign o_tick = (cnt_q == LAST_CNT);
   // lets the parent register a pulse that lands exactly on the terminal cycle
   assign o_pre_tick = (cnt_q == PRE_CNT) && !i_clear;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (i_clear || o_tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/arq_ack_tx.sv
// rtl/arq_ack_tx.sv - serializes one ACK/NAK word per received frame onto the ack line
module arq_ack_tx
   import otn_pkg::*;
#(
   parameter int         BIT_CYCLES = 16,
   parameter logic [7:0] ACK_CODE   = ACK_CODE_DEF,
   parameter logic [7:0] NAK_CODE   = NAK_CODE_DEF
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_arq_en,
   input  logic       i_frame_done,
   input  logic [7:0] i_crc_calc,
   input  logic [7:0] i_crc_rx,
   output logic       o_otn_rx_ack,
   output logic       o_busy,
   output logic       o_ack_sent,
   output logic [7:0] o_nak_count,
   output logic       o_overrun
);

   localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

   state_e     state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] word_q, word_d;
   logic       pend_full_q, pend_full_d;
   logic       pend_match_q, pend_match_d;
   logic       line_q, line_d;
   logic       busy_q, busy_d;
   logic       ack_sent_q, ack_sent_d;
   logic [7:0] nak_q, nak_d;
   logic       overrun_q, overrun_d;

   logic tick, pre_tick;
   logic ev, ev_match;
   logic load, load_match, slot_taken;

   assign ev       = i_frame_done & i_arq_en;
   assign ev_match = (i_crc_calc == i_crc_rx);

   bit_timer #(
      .BIT_CYCLES(BIT_CYCLES)
   ) u_bit_timer (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   (state_q == ST_IDLE),
      .o_tick    (tick),
      .o_pre_tick(pre_tick)
   );

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      word_d       = word_q;
      pend_full_d  = pend_full_q;
      pend_match_d = pend_match_q;
      line_d       = line_q;
      nak_d        = nak_q;
      overrun_d    = overrun_q;
      load         = 1'b0;
      load_match   = ev_match;
      slot_taken   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pend_full_q) begin
               load       = 1'b1;
               load_match = pend_match_q;
               slot_taken = 1'b1;
            end else if (ev) begin
               load = 1'b1;
            end
         end
         ST_START: begin
            if (tick) begin
               state_d = ST_DATA;
               idx_d   = '0;
               line_d  = word_q[0];
               word_d  = {1'b0, word_q[7:1]};
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_STOP;
                  line_d  = 1'b1;
               end else begin
                  idx_d  = idx_q + 3'd1;
                  line_d = word_q[0];
                  word_d = {1'b0, word_q[7:1]};
               end
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (pend_full_q) begin
                  load       = 1'b1;
                  load_match = pend_match_q;
                  slot_taken = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  line_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            line_d  = 1'b1;
         end
      endcase

      if (load) begin
         state_d = ST_START;
         line_d  = 1'b0;
         word_d  = load_match ? ACK_CODE : NAK_CODE;
         if (!load_match && (nak_q != 8'hFF)) begin
            nak_d = nak_q + 8'd1;
         end
      end

      if (slot_taken) begin
         pend_full_d = 1'b0;
      end

      // an event in IDLE with an empty slot went straight to the shifter above
      if (ev && !((state_q == ST_IDLE) && !pend_full_q)) begin
         if (pend_full_q && !slot_taken) begin
            overrun_d = 1'b1;
         end else begin
            pend_full_d  = 1'b1;
            pend_match_d = ev_match;
         end
      end

      busy_d     = (state_d != ST_IDLE);
      ack_sent_d = (state_q == ST_STOP) && pre_tick;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         word_q       <= '0;
         pend_full_q  <= 1'b0;
         pend_match_q <= 1'b0;
         line_q       <= 1'b1;
         busy_q       <= 1'b0;
         ack_sent_q   <= 1'b0;
         nak_q        <= '0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         word_q       <= word_d;
         pend_full_q  <= pend_full_d;
         pend_match_q <= pend_match_d;
         line_q       <= line_d;
         busy_q       <= busy_d;
         ack_sent_q   <= ack_sent_d;
         nak_q        <= nak_d;
         overrun_q    <= overrun_d;
      end
   end

   assign o_otn_rx_ack = line_q;
   assign o_busy       = busy_q;
   assign o_ack_sent   = ack_sent_q;
   assign o_nak_count  = nak_q;
   assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_arq_ack_tx.sv
// tb/tb_arq_ack_tx.sv - directed self-checking bench for arq_ack_tx
module tb_arq_ack_tx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       arq_en;
   logic       frame_done;
   logic [7:0] crc_calc;
   logic [7:0] crc_rx;
   logic       ack_line;
   logic       busy;
   logic       ack_sent;
   logic [7:0] nak_count;
   logic       overrun;

   int n_asserts = 0;
   int n_fails   = 0;

   arq_ack_tx #(
      .BIT_CYCLES(4),
      .ACK_CODE  (8'h06),
      .NAK_CODE  (8'h15)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst_n),
      .i_arq_en    (arq_en),
      .i_frame_done(frame_done),
      .i_crc_calc  (crc_calc),
      .i_crc_rx    (crc_rx),
      .o_otn_rx_ack(ack_line),
      .o_busy      (busy),
      .o_ack_sent  (ack_sent),
      .o_nak_count (nak_count),
      .o_overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_asserts++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one-cycle frame_done; returns at mid-cycle t+1
   task automatic frame_event(input logic [7:0] calc, input logic [7:0] rx);
      @(negedge clk);
      frame_done = 1'b1;
      crc_calc   = calc;
      crc_rx     = rx;
      @(negedge clk);
      frame_done = 1'b0;
   endtask

   // checks word cycles first_c..40 (cycle 1 = start bit's first cycle), BIT_CYCLES=4
   task automatic check_word(input logic [7:0] code, input logic [7:0] exp_nak, input int first_c);
      logic exp_line;
      for (int c = first_c; c <= 40; c++) begin
         if (c <= 4)       exp_line = 1'b0;
         else if (c <= 36) exp_line = code[(c - 5) / 4];
         else              exp_line = 1'b1;
         chk($sformatf("line_c%0d", c), {7'd0, ack_line}, {7'd0, exp_line});
         chk($sformatf("busy_c%0d", c), {7'd0, busy}, 8'd1);
         chk($sformatf("ack_sent_c%0d", c), {7'd0, ack_sent}, (c == 40) ? 8'd1 : 8'd0);
         if (c == 1 || c == 40) chk($sformatf("nak_count_c%0d", c), nak_count, exp_nak);
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      arq_en     = 1'b1;
      frame_done = 1'b0;
      crc_calc   = 8'h00;
      crc_rx     = 8'h00;
      repeat (3) @(negedge clk);

      chk("rst_line", {7'd0, ack_line}, 8'd1);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_ack_sent", {7'd0, ack_sent}, 8'd0);
      chk("rst_nak", nak_count, 8'd0);
      chk("rst_overrun", {7'd0, overrun}, 8'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // ACK word
      frame_event(8'hA5, 8'hA5);
      check_word(8'h06, 8'd0, 1);
      chk("ack_idle_busy", {7'd0, busy}, 8'd0);
      chk("ack_idle_line", {7'd0, ack_line}, 8'd1);
      chk("ack_nak", nak_count, 8'd0);
      repeat (3) @(negedge clk);

      // NAK word
      frame_event(8'h12, 8'h13);
      check_word(8'h15, 8'd1, 1);
      chk("nak_idle_busy", {7'd0, busy}, 8'd0);
      repeat (3) @(negedge clk);

      // ARQ disabled
      arq_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         frame_event(8'h12, 8'h34);
         for (int k = 0; k < 4; k++) begin
            chk("dis_line", {7'd0, ack_line}, 8'd1);
            chk("dis_busy", {7'd0, busy}, 8'd0);
            @(negedge clk);
         end
      end
      chk("dis_nak", nak_count, 8'd1);
      chk("dis_overrun", {7'd0, overrun}, 8'd0);
      arq_en = 1'b1;

      // queueing: ACK in flight, NAK queued, third event dropped
      frame_event(8'hA5, 8'hA5);
      frame_done = 1'b1;
      crc_calc   = 8'h12;
      crc_rx     = 8'h13;
      @(negedge clk);
      crc_calc   = 8'h77;
      crc_rx     = 8'h77;
      @(negedge clk);
      frame_done = 1'b0;
      chk("q_overrun", {7'd0, overrun}, 8'd1);
      check_word(8'h06, 8'd1, 3);
      check_word(8'h15, 8'd2, 1);
      for (int k = 0; k < 6; k++) begin
         chk("q_after_busy", {7'd0, busy}, 8'd0);
         chk("q_after_line", {7'd0, ack_line}, 8'd1);
         @(negedge clk);
      end
      chk("q_nak_final", nak_count, 8'd2);
      chk("q_overrun_sticky", {7'd0, overrun}, 8'd1);

      // reset mid-word (inside DATA), asynchronous recovery
      frame_event(8'h12, 8'h13);
      repeat (9) @(negedge clk);
      chk("mid_in_data_busy", {7'd0, busy}, 8'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_line", {7'd0, ack_line}, 8'd1);
      chk("mid_rst_busy", {7'd0, busy}, 8'd0);
      chk("mid_rst_nak", nak_count, 8'd0);
      chk("mid_rst_overrun", {7'd0, overrun}, 8'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_line", {7'd0, ack_line}, 8'd1);
      frame_event(8'h3C, 8'h3C);
      check_word(8'h06, 8'd0, 1);
      chk("post_rst_idle", {7'd0, busy}, 8'd0);

      // NAK saturation
      for (int i = 0; i < 260; i++) begin
         frame_event(8'h01, 8'h02);
         repeat (45) @(negedge clk);
         if (i == 253) chk("sat_254", nak_count, 8'd254);
         if (i == 254) chk("sat_255", nak_count, 8'd255);
      end
      chk("sat_final", nak_count, 8'd255);
      chk("sat_overrun", {7'd0, overrun}, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule

// File: doc/arq_ack_tx.md
# arq_ack_tx

Receiver-side ARQ acknowledgement transmitter. It drives the 1-bit return line that carries ACK/NAK back to the sender. For each completed OTN frame it compares the locally computed CRC with the received CRC field and serializes one UART-style response word (ACK or NAK) onto the ack line. The block sits inside the receiver, between the frame deframer/CRC checker and the `o_otn_rx_ack` output that the sender samples as `i_otn_tx_ack`.

## Interface
- `BIT_CYCLES`, 16, clock cycles per serialized bit; legal range 2..1024.
- `ACK_CODE`, 8'h06, response word sent on CRC match.
- `NAK_CODE`, 8'h15, response word sent on CRC mismatch.

- `i_clk` in 1: single clock.
- `i_rst` in 1: reset. Asynchronous and active-low.
- `i_arq_en` in 1: ARQ enable. When low, frame events are ignored and no response is sent.
- `i_frame_done` in 1: one-cycle pulse marking that a frame has been fully received.
- `i_crc_calc` in 8: locally computed CRC. Valid in the cycle `i_frame_done` is high.
- `i_crc_rx` in 8: CRC field received in the frame. Valid in the cycle `i_frame_done` is high.
- `o_otn_rx_ack` out 1: serial ack line. Idles high.
- `o_busy` out 1: high while a response word is being serialized.
- `o_ack_sent` out 1: one-cycle pulse in the last cycle of a stop bit.
- `o_nak_count` out 8: number of NAKs sent. Saturates at 255.
- `o_overrun` out 1: sticky flag. Set when a frame event is dropped; cleared only by reset.

## Operation
- **Reset values:** `o_otn_rx_ack`=1, `o_busy`=0, `o_ack_sent`=0, `o_nak_count`=0, `o_overrun`=0. Pending slot empty. State is IDLE.
- **Frame event:** `i_frame_done`=1 and `i_arq_en`=1.
  - The block evaluates `match = (i_crc_calc == i_crc_rx)`.
  - The selected code is `match ? ACK_CODE : NAK_CODE`.
- **Response word format:**
  - Start bit 0.
  - 8 data bits, LSB first.
  - Stop bit 1.
  - Each bit is held exactly `BIT_CYCLES` cycles, so one word lasts 10×`BIT_CYCLES` cycles.
- **State machine:**
  - IDLE → START on a frame event or when the pending slot is full.
  - START → DATA after `BIT_CYCLES` cycles.
  - DATA → STOP after 8 bits.
  - STOP → START if the pending slot is full, otherwise STOP → IDLE.
- **Counters:**
  - Bit-cycle counter is `$clog2(BIT_CYCLES)` wide and runs 0..`BIT_CYCLES`-1.
  - Bit index is 3 bits and does not wrap past 7; the DATA exit occurs at index 7 with a terminal cycle count.
- **One-deep pending slot:**
  - A frame event while `o_busy`=1 stores the code in the slot.
  - A frame event while the slot is already full is dropped and sets `o_overrun`.
  - If the slot empties (moves to the shifter) in the same cycle as a new event arrives, the new event is stored and nothing is dropped.
- **NAK counting:** `o_nak_count` increments when a NAK word is loaded into the shifter, not when it is queued.
- **Changes to `i_arq_en`:**
  - A word already in flight always completes.
  - Deasserting `i_arq_en` does not flush the pending slot.
- **Reset mid-word:** the line returns high asynchronously and the pending slot is discarded.

## Timing
- **Latency:**
  - Frame event in cycle t (IDLE, slot empty) → `o_otn_rx_ack`=0 and `o_busy`=1 from cycle t+1.
  - Data bit k occupies cycles t+1+(k+1)·`BIT_CYCLES` through t+(k+2)·`BIT_CYCLES`.
  - The stop bit ends at cycle t+10·`BIT_CYCLES`.
  - `o_ack_sent` pulses in cycle t+10·`BIT_CYCLES`.
  - `o_busy` falls at t+10·`BIT_CYCLES`+1, unless a word is pending.
- **Back-to-back words:** a pending word's start bit begins in the cycle right after the previous stop bit, with no idle gap.
- **Output registering:** all outputs are registered. `o_otn_rx_ack` has no combinational path from any input.

## Structure
- **Shared package `otn_pkg`:**
  - State enum (IDLE/START/DATA/STOP).
  - `ACK_CODE`/`NAK_CODE` defaults.
  - Word length constant (10 bits).
- **Sub-module `bit_timer`:**
  - Parameterized by `BIT_CYCLES`.
  - Inputs `i_clk`, `i_rst`, `i_clear`.
  - Output `o_tick`, a one-cycle pulse at the terminal count.
  - The parent holds the shifter, pending slot, state machine and counters.

## Test plan
- **ACK word:** `BIT_CYCLES`=4, `i_crc_calc`=`i_crc_rx`=8'hA5, event at t → line low t+1..t+4, then data bits 0,1,1,0,0,0,0,0 at 4 cycles each, high t+37..t+40, `o_ack_sent` pulse at t+40, `o_nak_count`=0.
- **NAK word:** `i_crc_calc`=8'h12, `i_crc_rx`=8'h13 → data bits 1,0,1,0,1,0,0,0, `o_nak_count`=1 from the cycle after the word is loaded.
- **ARQ disabled:** `i_arq_en`=0 with 5 frame events → line constantly high, `o_busy`=0, counters unchanged.
- **Queueing and overrun:** 3 events within one word time → exactly 2 words sent back-to-back with no high gap between the first stop bit and the second start bit, `o_overrun`=1.
- **Reset mid-word:** `i_rst` low during DATA → line high and `o_busy`=0 immediately; after release, a new event produces a clean full word.
- **NAK saturation:** 260 mismatched frames sent one at a time → `o_nak_count` stops at 255.
